// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard receiver: register map, bit positions,
// receive FSM encoding and the hex-to-segment table.
package ps2_kbd_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_PERR      = 3;
  localparam int ST_FERR      = 4;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Active-high segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ps2_kbd_fifo_if.sv
// Avalon-MM slave bus of the keyboard port: 2-bit address, 8-bit data, no waitrequest.
interface ps2_kbd_fifo_if;
  logic [1:0] address;
  logic       read;
  logic [7:0] readdata;
  logic       write;
  logic [7:0] writedata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/display2.sv
// One hex digit to seven segments, with selectable output polarity.
module display2
  import ps2_kbd_pkg::*;
#(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_hi;

  assign seg_hi = hex_to_seg(hex_i);
  assign seg_o  = ACT_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with flush; a full FIFO still accepts a push when popped in the same cycle.
module ps2_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: filtered kc/kd, frame decoder with watchdog, scancode FIFO,
// Avalon-MM register file, level IRQ and two-digit display of the last good byte.
module ps2_kbd_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit SSEG_ACT_LOW   = 1'b1
) (
  input  logic          csi_clk,
  input  logic          csi_reset_n,
  ps2_kbd_fifo_if.slave avs_s1,
  output logic          ins_irq0_irq,
  input  logic          coe_kc,
  input  logic          coe_kd,
  output logic [6:0]    coe_sseg0,
  output logic [6:0]    coe_sseg1
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- input synchronisers and glitch filters (bit 0 = kc, bit 1 = kd)
  logic [1:0] pin_raw, pin_filt;
  assign pin_raw = {coe_kd, coe_kc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_filt
    logic          sync1_q, sync2_q, filt_q;
    logic [FW-1:0] cnt_q;

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
      if (!csi_reset_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= pin_raw[gi];
        sync2_q <= sync1_q;
        if (sync2_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q <= sync2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + FW'(1);
        end
      end
    end

    assign pin_filt[gi] = filt_q;
  end

  logic kc_prev_q, kc_fall, kd;
  assign kc_fall = kc_prev_q & ~pin_filt[0];
  assign kd      = pin_filt[1];

  // ---------------- frame decoder
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          push_q, push_d;
  logic          timeout, perr_set, ferr_set;

  assign timeout = (state_q != S_IDLE) && (wd_q == WW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push_d    = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    wd_d      = (state_q == S_IDLE || kc_fall) ? '0 : wd_q + WW'(1);
    if (timeout) begin
      state_d = S_IDLE;
      shift_d = '0;
      wd_d    = '0;
      ferr_set = 1'b1;
    end else if (kc_fall) begin
      case (state_q)
        S_IDLE: begin
          if (!kd) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {kd, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = kd;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!kd)                               ferr_set = 1'b1;
          else if (!odd_parity_ok(shift_q, par_q)) perr_set = 1'b1;
          else                                   push_d   = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      kc_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      wd_q      <= '0;
      push_q    <= 1'b0;
    end else begin
      kc_prev_q <= pin_filt[0];
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      wd_q      <= wd_d;
      push_q    <= push_d;
    end
  end

  // ---------------- FIFO
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_flush;
  logic [CW-1:0] fifo_count;

  // shift_q is untouched between the STOP edge and the push cycle, so it is the byte.
  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (csi_clk),
    .rst_n (csi_reset_n),
    .push  (push_q),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- register file
  logic       ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic       irq_en_q, irq_en_d, irq_q;
  logic [7:0] readdata_q, rd_mux, last_q, status, w1c;
  logic       wr_status, wr_ctrl;

  assign wr_status  = avs_s1.write && (avs_s1.address == REG_STATUS);
  assign wr_ctrl    = avs_s1.write && (avs_s1.address == REG_CTRL);
  assign w1c        = wr_status ? avs_s1.writedata : 8'h00;
  assign fifo_pop   = avs_s1.read && (avs_s1.address == REG_DATA) && !fifo_empty;
  assign fifo_flush = wr_ctrl && avs_s1.writedata[CTRL_FLUSH];

  always_comb begin
    status               = 8'h00;
    status[ST_NOT_EMPTY] = ~fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_OVF]       = ovf_q;
    status[ST_PERR]      = perr_q;
    status[ST_FERR]      = ferr_q;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (avs_s1.address)
      REG_DATA:   rd_mux = fifo_empty ? 8'h00 : fifo_dout;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux = {7'd0, irq_en_q};
      default:    rd_mux = 8'(fifo_count);
    endcase
  end

  // A set in the same cycle as its W1C wins; a flush swallows a colliding push without OVF.
  always_comb begin
    ovf_d    = (ovf_q  & ~w1c[ST_OVF])  | (push_q & fifo_full & ~fifo_pop & ~fifo_flush);
    perr_d   = (perr_q & ~w1c[ST_PERR]) | perr_set;
    ferr_d   = (ferr_q & ~w1c[ST_FERR]) | ferr_set;
    irq_en_d = wr_ctrl ? avs_s1.writedata[CTRL_IRQ_EN] : irq_en_q;
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      readdata_q <= 8'h00;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      last_q     <= 8'h00;
    end else begin
      if (avs_s1.read) readdata_q <= rd_mux;
      if (push_q)      last_q     <= shift_q;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q & ~fifo_empty;
    end
  end

  assign avs_s1.readdata = readdata_q;
  assign ins_irq0_irq    = irq_q;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, avs_s1.writedata[7:5]};

  // ---------------- display of the last good byte
  display2 #(.ACT_LOW(SSEG_ACT_LOW)) u_dig_hi (.hex_i(last_q[7:4]), .seg_o(coe_sseg0));
  display2 #(.ACT_LOW(SSEG_ACT_LOW)) u_dig_lo (.hex_i(last_q[3:0]), .seg_o(coe_sseg1));

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Scoreboard bench for ps2_kbd_fifo: PS/2 frames and bus accesses drive a queue-based model;
// a monitor compares every read response against expected values queued at issue time.
module tb_ps2_kbd_fifo;
  import ps2_kbd_pkg::*;

  localparam int DEPTH = 16;
  localparam int FLEN  = 8;
  localparam int TMO   = 2000;
  localparam int HALF  = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       kc = 1'b1, kd = 1'b1;
  logic       irq;
  logic [6:0] seg0, seg1;

  ps2_kbd_fifo_if bus ();

  ps2_kbd_fifo #(
    .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO), .SSEG_ACT_LOW(1'b1)
  ) dut (
    .csi_clk     (clk),
    .csi_reset_n (rst_n),
    .avs_s1      (bus),
    .ins_irq0_irq(irq),
    .coe_kc      (kc),
    .coe_kd      (kd),
    .coe_sseg0   (seg0),
    .coe_sseg1   (seg1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_val[$];
  string      exp_name[$];

  // reference model
  logic [7:0] m_fifo[$];
  bit         m_ovf, m_perr, m_ferr, m_irq_en;
  logic [7:0] m_last;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111; 4'h1: s = 7'b0000110; 4'h2: s = 7'b1011011; 4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110; 4'h5: s = 7'b1101101; 4'h6: s = 7'b1111101; 4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111; 4'h9: s = 7'b1101111; 4'hA: s = 7'b1110111; 4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001; 4'hD: s = 7'b1011110; 4'hE: s = 7'b1111001; default: s = 7'b1110001;
    endcase
    return ~s;
  endfunction

  function automatic logic [7:0] m_status();
    return {3'b000, m_ferr, m_perr, m_ovf, m_fifo.size() == DEPTH, m_fifo.size() != 0};
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_ovf = 0; m_perr = 0; m_ferr = 0; m_irq_en = 0;
    m_last = 8'h00;
  endtask

  // monitor: one response per read, one cycle after the strobe
  initial begin : monitor
    string      nm;
    logic [7:0] v;
    forever begin
      @(posedge clk);
      if (rst_n && bus.read) begin
        #1;
        if (exp_val.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got %02h expected none", bus.readdata);
        end else begin
          nm = exp_name.pop_front();
          v  = exp_val.pop_front();
          check8(nm, bus.readdata, v);
        end
      end
    end
  end

  initial begin : watchdog
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input string nm);
    logic [7:0] e;
    case (a)
      REG_DATA:   e = (m_fifo.size() > 0) ? m_fifo.pop_front() : 8'h00;
      REG_STATUS: e = m_status();
      REG_CTRL:   e = {7'd0, m_irq_en};
      default:    e = 8'(m_fifo.size());
    endcase
    exp_val.push_back(e);
    exp_name.push_back(nm);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    if (a == REG_STATUS) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_perr = 0;
      if (d[4]) m_ferr = 0;
    end else if (a == REG_CTRL) begin
      m_irq_en = d[0];
      if (d[1]) m_fifo.delete();
    end
    $display("write addr=%0d data=%02h", a, d);
  endtask

  // bits are sent LSB first; kd changes while kc is high, device-style
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      kd = bits[i];
      if (glitch && i[0]) begin
        settle(8); kc = 1'b0; settle(3); kc = 1'b1; settle(HALF - 11);
      end else begin
        settle(HALF);
      end
      kc = 1'b0;
      if (glitch && !i[0]) begin
        settle(10); kc = 1'b1; settle(3); kc = 1'b0; settle(HALF - 13);
      end else begin
        settle(HALF);
      end
      kc = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11, glitch);
    kd = 1'b1;
    settle(HALF);
    if (bad_stop)     m_ferr = 1;
    else if (bad_par) m_perr = 1;
    else begin
      m_last = b;
      if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
      else m_ovf = 1;
    end
    $display("frame byte=%02h bad_par=%0d bad_stop=%0d glitch=%0d", b, bad_par, bad_stop, glitch);
  endtask

  task automatic check_outputs(input string tag);
    settle(2);
    check8({tag, "_irq"},  {7'd0, irq}, {7'd0, m_irq_en && (m_fifo.size() != 0)});
    check8({tag, "_seg0"}, {1'b0, seg0}, {1'b0, seg_of(m_last[7:4])});
    check8({tag, "_seg1"}, {1'b0, seg1}, {1'b0, seg_of(m_last[3:0])});
  endtask

  initial begin : stimulus
    int r;
    bus.address = 2'd0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = 8'h00;
    model_reset();
    #2 rst_n = 1'b0;
    settle(3);
    check8("rst_readdata", bus.readdata, 8'h00);
    check_outputs("rst");
    rst_n = 1'b1;
    settle(2);
    rd(REG_STATUS, "rst_status");
    rd(REG_COUNT, "rst_count");
    rd(REG_CTRL, "rst_ctrl");

    // single good frame
    send_frame(8'h1C, 0, 0, 0);
    rd(REG_STATUS, "t1_status");
    rd(REG_COUNT, "t1_count");
    check_outputs("t1");
    rd(REG_DATA, "t1_data");
    rd(REG_STATUS, "t1_status_after");

    // interrupt raise and drop
    wr(REG_CTRL, 8'h01);
    send_frame(8'hF0, 0, 0, 0);
    check_outputs("t2_raise");
    rd(REG_DATA, "t2_data");
    check_outputs("t2_drop");

    // parity error and W1C
    send_frame(8'h5A, 1, 0, 0);
    rd(REG_COUNT, "t3_count");
    rd(REG_STATUS, "t3_status");
    wr(REG_STATUS, 8'h08);
    rd(REG_STATUS, "t3_status_clr");

    // overflow
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 0, 0, 0);
    rd(REG_COUNT, "t4_count");
    rd(REG_STATUS, "t4_status");
    check_outputs("t4");
    for (int i = 0; i < DEPTH; i++) rd(REG_DATA, $sformatf("t4_data%0d", i));
    rd(REG_STATUS, "t4_status_empty");
    wr(REG_STATUS, 8'h04);

    // watchdog timeout after 5 bits, then recovery
    send_bits({2'b11, 8'h29, 1'b0}, 5, 0);
    kd = 1'b1;
    settle(TMO + 200);
    m_ferr = 1;
    rd(REG_STATUS, "t5_status");
    send_frame(8'h29, 0, 0, 0);
    rd(REG_COUNT, "t5_count");
    rd(REG_DATA, "t5_data");
    wr(REG_STATUS, 8'h10);

    // filtered glitches
    send_frame(8'hA7, 0, 0, 1);
    send_frame(8'h3E, 0, 0, 1);
    check_outputs("t6");
    rd(REG_DATA, "t6_data0");
    rd(REG_DATA, "t6_data1");

    // flush
    send_frame(8'h44, 0, 0, 0);
    wr(REG_CTRL, 8'h03);
    rd(REG_COUNT, "flush_count");
    rd(REG_CTRL, "flush_ctrl");

    // randomized mix
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) == 0);
      end else if (r <= 6) begin
        rd(2'($urandom_range(0, 3)), $sformatf("rnd%0d_rd", it));
      end else if (r == 7) begin
        wr(REG_STATUS, 8'($urandom));
      end else if (r == 8) begin
        wr(REG_CTRL, {6'd0, $urandom_range(0, 3) == 0, 1'($urandom)});
      end else begin
        wr(($urandom_range(0, 1) == 0) ? REG_DATA : REG_COUNT, 8'($urandom));
      end
      check_outputs($sformatf("rnd%0d", it));
    end
    rd(REG_STATUS, "rnd_status");
    rd(REG_COUNT, "rnd_count");
    while (m_fifo.size() > 0) rd(REG_DATA, "rnd_drain");

    // asynchronous reset in the middle of a frame
    wr(REG_STATUS, 8'h1C);
    wr(REG_CTRL, 8'h01);
    send_frame(8'h3B, 0, 0, 0);
    rd(REG_STATUS, "pre_rst_status");
    check_outputs("pre_rst");
    send_bits({2'b11, 8'h55, 1'b0}, 4, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check8("midrst_readdata", bus.readdata, 8'h00);
    check8("midrst_irq", {7'd0, irq}, 8'h00);
    check8("midrst_seg0", {1'b0, seg0}, {1'b0, seg_of(4'h0)});
    check8("midrst_seg1", {1'b0, seg1}, {1'b0, seg_of(4'h0)});
    kc = 1'b1; kd = 1'b1;
    settle(4);
    rst_n = 1'b1;
    settle(2);
    rd(REG_STATUS, "post_rst_status");
    rd(REG_COUNT, "post_rst_count");
    rd(REG_CTRL, "post_rst_ctrl");
    send_frame(8'h66, 0, 0, 0);
    rd(REG_DATA, "post_rst_data");
    check_outputs("post_rst");

    settle(3);
    check8("scoreboard_drain", 8'(exp_val.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
